// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } uart_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port plus transmitter data/start/busy handshake.
interface uart_tx_fifo_if import uart_pkg::*; ();

    logic [UART_DATA_W-1:0] wr_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [UART_DATA_W-1:0] uart_data;
    logic                   uart_start;
    logic                   uart_busy;

    modport master (
        output wr_data, wr_valid, uart_busy,
        input  wr_ready, uart_data, uart_start
    );

    modport slave (
        input  wr_data, wr_valid, uart_busy,
        output wr_ready, uart_data, uart_start
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy is a counter so full/empty stay unambiguous at wrap.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + LVL_W'(push) - LVL_W'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;
    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART front end: queues bus writes and launches them one at a time
// into the transmitter through its data/start/busy handshake.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_fifo_if.slave    bus,
    input  logic             ovf_clr,
    output logic             overflow,
    output logic [LVL_W-1:0] level,
    output logic             empty
);

    uart_fifo_state_t       state;
    uart_fifo_state_t       state_next;
    logic                   full;
    logic                   push;
    logic                   launch;
    logic [UART_DATA_W-1:0] head;
    logic                   start_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   ovf_q;

    // wr_ready comes from full before any same-cycle pop, so a full FIFO refuses
    // the write even on the edge that frees a slot.
    assign push         = bus.wr_valid && !full;
    assign bus.wr_ready = !full;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus.wr_data),
        .pop     (launch),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (launch)         state_next = ST_LAUNCH;
            ST_LAUNCH:                        state_next = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (bus.uart_busy)  state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!bus.uart_busy) state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        launch = 1'b0;
        if (state == ST_IDLE && !empty && !bus.uart_busy) begin
            launch = 1'b1;
        end
    end

    // Data only loads on a launch, so it stays stable for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            data_q  <= '0;
        end else begin
            start_q <= launch;
            if (launch) begin
                data_q <= head;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_valid && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.uart_start = start_q;
    assign bus.uart_data  = data_q;
    assign overflow       = ovf_q;

endmodule
